// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver: digit register file, DISPLAY/BLANK scan FSM,
// and registered active-low segment and anode outputs with one dead cycle between digits.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] digit_en,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG,
    output logic       DP,
    output logic [7:0] AN,
    output logic       frame_done
);

    typedef enum logic {
        ST_DISPLAY = 1'b0,
        ST_BLANK   = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    // Hex digit to {a..g}, active-low.
    function automatic logic [6:0] seg7_decode(input logic [3:0] hex);
        case (hex)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    logic [4:0]  digit_mem [8];
    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [4:0]  cur_entry;
    logic        show;

    logic [7:0]  an_p0;
    logic [6:0]  seg_p0;
    logic        dp_p0;
    logic        frame_done_p0;

    assign cur_entry = digit_mem[idx];
    assign show      = (state == ST_DISPLAY) && digit_en[idx];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 8; i++) digit_mem[i] <= 5'b00000;
        end else if (wr_en) begin
            digit_mem[wr_addr] <= wr_data;
        end
    end

    // Stage p0: outputs are computed from the state, index and digit data present before the edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_DISPLAY;
            cnt           <= 16'd0;
            idx           <= 3'd0;
            an_p0         <= 8'hFF;
            seg_p0        <= 7'h7F;
            dp_p0         <= 1'b1;
            frame_done_p0 <= 1'b0;
        end else begin
            an_p0         <= show ? ~(8'd1 << idx) : 8'hFF;
            seg_p0        <= show ? seg7_decode(cur_entry[3:0]) : 7'h7F;
            dp_p0         <= show ? ~cur_entry[4] : 1'b1;
            frame_done_p0 <= (state == ST_BLANK) && (idx == 3'd7);
            case (state)
                ST_DISPLAY: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_DISPLAY;
                    idx   <= idx + 3'd1;
                end
            endcase
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg_p0;
    assign DP         = dp_p0;
    assign AN         = an_p0;
    assign frame_done = frame_done_p0;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=4): scan order, blanking, writes,
// digit enables, frame pulse and asynchronous reset, all against hand-derived slot values.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [4:0] wr_data = 5'd0;
    logic [7:0] digit_en = 8'hFF;
    logic       CA, CB, CC, CD, CE, CF, CG, DP, frame_done;
    logic [7:0] AN;

    int n_checks = 0;
    int n_err    = 0;
    int g        = 0;   // output cycles since reset release

    logic [4:0] mem_m [8];
    logic [7:0] en_m;

    // {CA..CG} for 0..F, entered from the decode table
    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_scan_driver #(.SCAN_DIV(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .digit_en(digit_en), .CA(CA), .CB(CB), .CC(CC), .CD(CD),
        .CE(CE), .CF(CF), .CG(CG), .DP(DP), .AN(AN), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " AN"}, 32'(AN), 32'hFF);
        check_val({tag, " seg"}, 32'({CA, CB, CC, CD, CE, CF, CG}), 32'h7F);
        check_val({tag, " DP"}, 32'(DP), 32'd1);
        check_val({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // One clock; optional write issued on this edge. Outputs checked against the slot model.
    task automatic step(input bit do_wr, input logic [2:0] a, input logic [4:0] d);
        int k, pos;
        bit on;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        wr_en = do_wr; wr_addr = a; wr_data = d;
        @(posedge sys_clk);
        @(negedge sys_clk);
        wr_en = 1'b0;
        g++;
        k   = ((g - 1) / 5) % 8;
        pos = (g - 1) % 5;
        on  = (pos < 4) && en_m[k];
        e_an  = on ? ~(8'd1 << k) : 8'hFF;
        e_seg = on ? dec_tab[mem_m[k][3:0]] : 7'h7F;
        e_dp  = on ? ~mem_m[k][4] : 1'b1;
        check_val($sformatf("AN g=%0d", g), 32'(AN), 32'(e_an));
        check_val($sformatf("seg g=%0d", g), 32'({CA, CB, CC, CD, CE, CF, CG}), 32'(e_seg));
        check_val($sformatf("DP g=%0d", g), 32'(DP), 32'(e_dp));
        check_val($sformatf("frame_done g=%0d", g), 32'(frame_done),
                  32'((pos == 4 && k == 7) ? 1 : 0));
        if (do_wr) mem_m[a] = d;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 5'd0);
    endtask

    task automatic set_en(input logic [7:0] v);
        digit_en = v;
        en_m     = v;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_m[i] = 5'd0;
        en_m = 8'hFF;

        // Reset held across several edges
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        g = 0;
        #1;
        check_reset_outputs("post-release");

        // Three free-running frames of zeros with frame pulses
        run(120);

        // Digit 3 = A with decimal point
        step(1'b1, 3'd3, 5'b1_1010);
        run(79);

        // Write digit 0 while it is on display
        run(1);
        step(1'b1, 3'd0, 5'h07);
        run(78);
        check_val("digit0 after rewrite AN", 32'(AN), 32'hFF);

        // Odd digits disabled for a frame
        set_en(8'h55);
        run(42);
        // Digit 0 disabled mid-digit, then everything re-enabled mid-digit
        set_en(8'hFE);
        run(20);
        set_en(8'hFF);
        run(18);

        // Load more digits, then reset in the middle of digit 5
        step(1'b1, 3'd5, 5'h1C);
        step(1'b1, 3'd7, 5'h0F);
        while (!(((g - 1) / 5) % 8 == 5 && (g - 1) % 5 == 1)) step(1'b0, 3'd0, 5'd0);
        check_val("pre-reset digit5 AN", 32'(AN), 32'hDF);
        #1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'h1F;
        #1;
        sys_rst = 1'b1;
        #0.5;
        check_reset_outputs("async reset");
        #0.5;
        sys_rst = 1'b0;
        wr_en   = 1'b0;
        for (int i = 0; i < 8; i++) mem_m[i] = 5'd0;
        g = 0;
        check_reset_outputs("after async release");
        run(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
